// File: rtl/adventure_game_ctrl.sv
// Room-sequencing controller for the adventure game: synchronises four direction
// buttons, walks the room map and drives one-hot room, sword/win/dead and a move counter.
module adventure_game_ctrl #(
    parameter int DEN_DWELL = 16,
    parameter int MOVE_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_btn_n,
    input  logic              i_btn_s,
    input  logic              i_btn_e,
    input  logic              i_btn_w,
    input  logic              i_restart,
    output logic [8:0]        o_digit_data,
    output logic              o_sword,
    output logic              o_win,
    output logic              o_dead,
    output logic [MOVE_W-1:0] o_move_count
);

    localparam logic [2:0] ROOM_CAVE    = 3'd0;
    localparam logic [2:0] ROOM_TUNNEL  = 3'd1;
    localparam logic [2:0] ROOM_RIVER   = 3'd2;
    localparam logic [2:0] ROOM_STASH   = 3'd3;
    localparam logic [2:0] ROOM_DEN     = 3'd4;
    localparam logic [2:0] ROOM_VICTORY = 3'd5;
    localparam logic [2:0] ROOM_GRAVE   = 3'd6;

    localparam int DW = (DEN_DWELL > 1) ? $clog2(DEN_DWELL) : 1;

    // Button vectors are ordered {N, S, E, W} so the MSB has top priority.
    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [3:0]        r_prev;
    logic [2:0]        r_room;
    logic [DW-1:0]     r_dwell;
    logic [8:0]        r_digit;
    logic              r_sword;
    logic              r_win;
    logic              r_dead;
    logic [MOVE_W-1:0] r_moves;

    logic [3:0]        w_press;
    logic              w_go_n;
    logic              w_go_s;
    logic              w_go_e;
    logic              w_go_w;
    logic [2:0]        w_room_next;
    logic [DW-1:0]     w_dwell_next;
    logic              w_sword_next;
    logic              w_move;

    assign w_press = r_sync2 & ~r_prev;
    assign w_go_n  = w_press[3];
    assign w_go_s  = w_press[2] & ~w_press[3];
    assign w_go_e  = w_press[1] & ~(|w_press[3:2]);
    assign w_go_w  = w_press[0] & ~(|w_press[3:1]);

    always_comb begin
        w_room_next  = r_room;
        w_dwell_next = r_dwell;
        w_sword_next = r_sword;
        w_move       = 1'b0;
        case (r_room)
            ROOM_CAVE: begin
                if (w_go_e) begin
                    w_room_next = ROOM_TUNNEL;
                    w_move      = 1'b1;
                end
            end
            ROOM_TUNNEL: begin
                if (w_go_s) begin
                    w_room_next = ROOM_RIVER;
                    w_move      = 1'b1;
                end else if (w_go_w) begin
                    w_room_next = ROOM_CAVE;
                    w_move      = 1'b1;
                end
            end
            ROOM_RIVER: begin
                if (w_go_n) begin
                    w_room_next = ROOM_TUNNEL;
                    w_move      = 1'b1;
                end else if (w_go_e) begin
                    w_room_next  = ROOM_DEN;
                    w_dwell_next = DW'(DEN_DWELL - 1);
                    w_move       = 1'b1;
                end else if (w_go_w) begin
                    w_room_next  = ROOM_STASH;
                    w_sword_next = 1'b1;
                    w_move       = 1'b1;
                end
            end
            ROOM_STASH: begin
                if (w_go_e) begin
                    w_room_next = ROOM_RIVER;
                    w_move      = 1'b1;
                end
            end
            ROOM_DEN: begin
                if (r_dwell == '0) begin
                    w_room_next = r_sword ? ROOM_VICTORY : ROOM_GRAVE;
                end else begin
                    w_dwell_next = r_dwell - 1'b1;
                end
            end
            default: ;
        endcase
        // Restart overrides everything, including a press arriving the same cycle.
        if (i_restart) begin
            w_room_next  = ROOM_CAVE;
            w_dwell_next = '0;
            w_sword_next = 1'b0;
            w_move       = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= {i_btn_n, i_btn_s, i_btn_e, i_btn_w};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_room  <= ROOM_CAVE;
            r_dwell <= '0;
            r_digit <= 9'h001;
            r_sword <= 1'b0;
            r_win   <= 1'b0;
            r_dead  <= 1'b0;
            r_moves <= '0;
        end else begin
            r_room  <= w_room_next;
            r_dwell <= w_dwell_next;
            r_digit <= 9'd1 << w_room_next;
            r_sword <= w_sword_next;
            r_win   <= (w_room_next == ROOM_VICTORY);
            r_dead  <= (w_room_next == ROOM_GRAVE);
            if (i_restart) begin
                r_moves <= '0;
            end else if (w_move && (r_moves != '1)) begin
                r_moves <= r_moves + 1'b1;
            end
        end
    end

    assign o_digit_data = r_digit;
    assign o_sword      = r_sword;
    assign o_win        = r_win;
    assign o_dead       = r_dead;
    assign o_move_count = r_moves;

endmodule
